// File: rtl/music_pkg.sv
// Shared note-code constants, duration encoding, table entry layout and sequencer states.
// Also used by the downstream tone generator.
package music_pkg;

  localparam logic [5:0] NOTE_REST      = 6'd0;
  localparam logic [5:0] NOTE_END       = 6'd63;
  localparam logic [5:0] NOTE_LOW_BASE  = 6'd1;
  localparam logic [5:0] NOTE_MID_BASE  = 6'd8;
  localparam logic [5:0] NOTE_HIGH_BASE = 6'd15;
  localparam logic [5:0] NOTE_MAX       = 6'd21;

  // Note length in units is 1 << dur.
  typedef enum logic [1:0] {
    DUR_1 = 2'b00,
    DUR_2 = 2'b01,
    DUR_4 = 2'b10,
    DUR_8 = 2'b11
  } dur_e;

  typedef struct packed {
    logic [1:0] dur;
    logic [5:0] code;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_GAP,
    ST_PLAY,
    ST_DONE
  } state_e;

  function automatic logic mode_valid(input logic [2:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
  endfunction

  function automatic logic [1:0] mode_to_sel(input logic [2:0] m);
    case (m)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous note-table ROM holding the three songs; one-cycle read latency.
// Unprogrammed locations read back as the end marker.
module song_rom
  import music_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic [ADDR_W+1:0] rd_addr,
  output entry_t            rd_dat
);

  function automatic entry_t mk(input dur_e d, input logic [5:0] c);
    return '{dur: d, code: c};
  endfunction

  logic [1:0] sel;
  int         idx;
  entry_t     rom_d;
  entry_t     rd_dat_q;

  assign sel = rd_addr[ADDR_W +: 2];
  assign idx = int'(rd_addr[ADDR_W-1:0]);

  always_comb begin
    rom_d = mk(DUR_1, NOTE_END);
    case (sel)
      2'd0: begin
        case (idx)
          0:       rom_d = mk(DUR_1, 6'd8);
          1:       rom_d = mk(DUR_2, 6'd9);
          default: rom_d = mk(DUR_1, NOTE_END);
        endcase
      end
      2'd1: begin
        case (idx)
          0:       rom_d = mk(DUR_1, NOTE_REST);
          1:       rom_d = mk(DUR_2, 6'd15);
          2:       rom_d = mk(DUR_1, 6'd40);
          default: rom_d = mk(DUR_1, NOTE_END);
        endcase
      end
      2'd2: begin
        case (idx)
          0:       rom_d = mk(DUR_1, 6'd21);
          1:       rom_d = mk(DUR_1, 6'd45);
          2:       rom_d = mk(DUR_8, 6'd1);
          default: rom_d = mk(DUR_1, NOTE_END);
        endcase
      end
      default: rom_d = mk(DUR_1, NOTE_END);
    endcase
  end

  always_ff @(posedge clk) begin
    rd_dat_q <= rom_d;
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/song_sequencer.sv
// Walks the selected song's note table and presents one note code at a time, with a
// silent articulation gap at the head of each note; all outputs registered.
module song_sequencer
  import music_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000,
  parameter int          ADDR_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [5:0] note_code,
  output logic       silent,
  output logic       busy,
  output logic       done
);

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [5:0]        code_q, code_d;
  logic [31:0]       note_len_q, note_len_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [5:0]        note_code_q, note_code_d;
  logic              silent_q, silent_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  entry_t            rom_dat;
  logic              mode_ok;
  logic [1:0]        mode_sel;
  logic              active;
  logic [31:0]       cnt_inc;
  logic [5:0]        play_code;

  // The ROM is addressed with next-state values so FETCH sees its entry immediately.
  song_rom #(.ADDR_W(ADDR_W)) u_rom (
    .clk     (clk),
    .rd_addr ({sel_d, addr_d}),
    .rd_dat  (rom_dat)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    code_d     = code_q;
    note_len_d = note_len_q;
    cnt_d      = cnt_q;
    mode_ok    = mode_valid(mode);
    mode_sel   = mode_to_sel(mode);
    active     = (state_q == ST_FETCH) || (state_q == ST_GAP) || (state_q == ST_PLAY);
    cnt_inc    = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    if (stop || (active && !mode_ok)) begin
      state_d = ST_IDLE;
    end else if ((start && mode_ok) || (active && (mode_sel != sel_q))) begin
      state_d = ST_FETCH;
      sel_d   = mode_sel;
      addr_d  = '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (rom_dat.code == NOTE_END) begin
            if (loop) addr_d = '0;
            else      state_d = ST_DONE;
          end else begin
            code_d     = rom_dat.code;
            note_len_d = 32'(UNIT_CYCLES) << rom_dat.dur;
            cnt_d      = '0;
            state_d    = ST_GAP;
          end
        end
        ST_GAP: begin
          cnt_d = cnt_inc;
          if (cnt_q >= 32'(GAP_CYCLES) - 32'd1) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          cnt_d = cnt_inc;
          if (cnt_q >= note_len_q - 32'd1) begin
            // Running off the last table slot behaves like hitting the end marker.
            if (addr_q == '1) begin
              if (loop) begin
                addr_d  = '0;
                state_d = ST_FETCH;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_FETCH;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end

    play_code   = (code_d <= NOTE_MAX) ? code_d : NOTE_REST;
    silent_d    = !((state_d == ST_PLAY) && (play_code != NOTE_REST));
    note_code_d = silent_d ? NOTE_REST : play_code;
    busy_d      = (state_d == ST_FETCH) || (state_d == ST_GAP) || (state_d == ST_PLAY);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      code_q      <= NOTE_REST;
      note_len_q  <= '0;
      cnt_q       <= '0;
      note_code_q <= NOTE_REST;
      silent_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      code_q      <= code_d;
      note_len_q  <= note_len_d;
      cnt_q       <= cnt_d;
      note_code_q <= note_code_d;
      silent_q    <= silent_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign note_code = note_code_q;
  assign silent    = silent_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed vectors and sequences, then random stimulus vs a note-timeline model.
module tb_song_sequencer;

  localparam int unsigned UNIT = 10;
  localparam int unsigned GAP  = 2;

  logic       clk = 1'b0;
  logic       rst, start, stop, loop;
  logic [2:0] mode;
  logic [5:0] note_code;
  logic       silent, busy, done;

  always #5 clk = ~clk;

  song_sequencer #(.UNIT_CYCLES(UNIT), .GAP_CYCLES(GAP), .ADDR_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .note_code (note_code),
    .silent    (silent),
    .busy      (busy),
    .done      (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int code, input int sil, input int bsy, input int dn);
    chk({tag, ".note_code"}, int'(note_code), code);
    chk({tag, ".silent"}, int'(silent), sil);
    chk({tag, ".busy"}, int'(busy), bsy);
    chk({tag, ".done"}, int'(done), dn);
  endtask

  // Pulse start at the current sampling point; returns at the sample point of cycle t+1.
  task automatic go(input logic [2:0] m);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- reference model: song position as (entry index, offset in entry period)
  logic [7:0] tab [0:2][0:63];
  logic       m_act  = 1'b0;
  logic       m_done = 1'b0;
  int         m_song = 0;
  int         m_idx  = 0;
  int         m_off  = 0;
  logic [7:0] m_ent;
  int         m_units, m_code, m_pc;
  logic [5:0] exp_code;
  logic       exp_silent;

  function automatic logic vmode(input logic [2:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
  endfunction

  function automatic int msong(input logic [2:0] m);
    return (m == 3'b010) ? 1 : (m == 3'b100) ? 2 : 0;
  endfunction

  always_comb begin
    m_ent      = tab[m_song][m_idx];
    m_units    = 1 << m_ent[7:6];
    m_code     = int'(m_ent[5:0]);
    m_pc       = (m_code <= 21) ? m_code : 0;
    exp_code   = 6'd0;
    exp_silent = 1'b1;
    // Offset 0 is the fetch, 1..GAP the gap, the rest of the period is sound.
    if (m_act && m_code != 63 && m_off > int'(GAP)) begin
      exp_code   = 6'(m_pc);
      exp_silent = (m_pc == 0);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
      m_idx  <= 0;
      m_off  <= 0;
    end else begin
      m_done <= 1'b0;
      if (stop || (m_act && !vmode(mode))) begin
        m_act <= 1'b0;
      end else if ((start && vmode(mode)) || (m_act && msong(mode) != m_song)) begin
        m_act  <= 1'b1;
        m_song <= msong(mode);
        m_idx  <= 0;
        m_off  <= 0;
      end else if (m_act) begin
        if (m_code == 63) begin
          if (loop) m_idx <= 0;
          else begin m_act <= 1'b0; m_done <= 1'b1; end
        end else if (m_off == m_units * int'(UNIT)) begin
          if (m_idx == 63) begin
            if (loop) begin m_idx <= 0; m_off <= 0; end
            else begin m_act <= 1'b0; m_done <= 1'b1; end
          end else begin
            m_idx <= m_idx + 1;
            m_off <= 0;
          end
        end else begin
          m_off <= m_off + 1;
        end
      end
    end
  end

  // ---------------- directed vectors for song 0: {8,1u},{9,2u},{END}
  typedef struct {
    int         cyc;
    logic [2:0] mode;
    logic       loop;
    logic [5:0] code;
    logic       sil;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t vt [11];

  initial begin
    int vi, dcnt, n8, n9, bad;

    for (int s = 0; s < 3; s++)
      for (int a = 0; a < 64; a++) tab[s][a] = 8'h3F;
    tab[0][0] = {2'b00, 6'd8};
    tab[0][1] = {2'b01, 6'd9};
    tab[1][0] = {2'b00, 6'd0};
    tab[1][1] = {2'b01, 6'd15};
    tab[1][2] = {2'b00, 6'd40};
    tab[2][0] = {2'b00, 6'd21};
    tab[2][1] = {2'b00, 6'd45};
    tab[2][2] = {2'b11, 6'd1};

    vt[0]  = '{1,  3'b001, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0};
    vt[1]  = '{3,  3'b001, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{4,  3'b001, 1'b0, 6'd8, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{11, 3'b001, 1'b0, 6'd8, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{12, 3'b001, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{14, 3'b001, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{15, 3'b001, 1'b0, 6'd9, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{32, 3'b001, 1'b0, 6'd9, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{33, 3'b001, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{34, 3'b001, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1};
    vt[10] = '{35, 3'b001, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; mode = 3'b001;
    repeat (2) @(negedge clk);
    chk_out("reset", 0, 1, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Song 0 playback against the vector table.
    mode  = vt[0].mode;
    loop  = vt[0].loop;
    start = 1'b1;
    vi = 0; dcnt = 0; n8 = 0; n9 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dcnt++;
      if (note_code == 6'd8 && !silent) n8++;
      if (note_code == 6'd9 && !silent) n9++;
      if (vi < 11 && vt[vi].cyc == c) begin
        chk_out($sformatf("song0_c%0d", c), int'(vt[vi].code), int'(vt[vi].sil),
                int'(vt[vi].bsy), int'(vt[vi].dn));
        vi++;
      end
    end
    chk("song0_done_pulses", dcnt, 1);
    chk("song0_code8_cycles", n8, 8);
    chk("song0_code9_cycles", n9, 18);

    // Song 1: rest entry, note 15, out-of-range code 40 plays as rest.
    go(3'b010);
    bad = 0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) @(negedge clk);
      if (!silent || note_code != 6'd0) bad++;
    end
    chk("rest_entry_audible_cycles", bad, 0);
    repeat (4) @(negedge clk);
    chk_out("song1_c15", 15, 0, 1, 0);
    repeat (21) @(negedge clk);
    chk_out("song1_code40_rest", 0, 1, 1, 0);
    repeat (9) @(negedge clk);
    chk_out("song1_done", 0, 1, 0, 1);
    @(negedge clk);

    // Looping song 0, then stop mid-note.
    loop = 1'b1;
    go(3'b001);
    dcnt = 0;
    for (int k = 1; k <= 51; k++) begin
      if (k > 1) @(negedge clk);
      if (done) dcnt++;
      if (k == 36) chk_out("loop_gap_c36", 0, 1, 1, 0);
      if (k == 37) chk_out("loop_replay_c37", 8, 0, 1, 0);
      if (k == 44) chk_out("loop_replay_c44", 8, 0, 1, 0);
      if (k == 45) chk_out("loop_fetch_c45", 0, 1, 1, 0);
      if (k == 50) begin
        chk_out("loop_note9_c50", 9, 0, 1, 0);
        stop = 1'b1;
      end
      if (k == 51) begin
        stop = 1'b0;
        chk_out("loop_stopped", 0, 1, 0, 0);
      end
    end
    chk("loop_done_pulses", dcnt, 0);
    loop = 1'b0;
    @(negedge clk);

    // Mode change mid-play restarts song 1 at entry 0; invalid mode stops.
    go(3'b001);
    for (int k = 1; k <= 28; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 6) begin
        chk_out("mchg_c6", 8, 0, 1, 0);
        mode = 3'b010;
      end
      if (k == 7)  chk_out("mchg_fetch", 0, 1, 1, 0);
      if (k == 10) chk_out("mchg_rest", 0, 1, 1, 0);
      if (k == 20) chk_out("mchg_gap2", 0, 1, 1, 0);
      if (k == 21) chk_out("mchg_note15", 15, 0, 1, 0);
      if (k == 25) mode = 3'b011;
      if (k == 26) begin
        chk_out("mchg_invalid", 0, 1, 0, 0);
        mode = 3'b001;
      end
      if (k == 28) chk_out("mchg_stays_idle", 0, 1, 0, 0);
    end

    // start and stop together while idle.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk_out("start_stop_idle", 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    chk_out("start_stop_idle_later", 0, 1, 0, 0);

    // Start with invalid mode is ignored.
    go(3'b110);
    chk_out("start_invalid_mode", 0, 1, 0, 0);

    // Reset mid-play.
    go(3'b001);
    repeat (5) @(negedge clk);
    chk_out("rst_pre_c6", 8, 0, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_out("rst_mid_play", 0, 1, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_out("rst_after", 0, 1, 0, 0);

    // Random stimulus against the model.
    mode = 3'b001; loop = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      chk("rnd.note_code", int'(note_code), int'(exp_code));
      chk("rnd.silent", int'(silent), int'(exp_silent));
      chk("rnd.busy", int'(busy), int'(m_act));
      chk("rnd.done", int'(done), int'(m_done));
      rst   = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 119) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: mode = 3'b001;
          3, 4, 5: mode = 3'b010;
          6, 7:    mode = 3'b100;
          default: mode = 3'($urandom_range(0, 7));
        endcase
      end
      if ($urandom_range(0, 249) == 0) loop = ~loop;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
